// File: rtl/avalon_regfile_slave_if.sv
// Avalon-MM bus bundle for avalon_regfile_slave.
// Groups the command, write-data and read-response signals of one Avalon-MM
// link. The master modport drives commands; the slave modport returns read
// data, read-valid and the stall signal.
//   ADDRESS            byte address
//   BYTEENABLE         per-byte write strobe
//   READ / WRITE       command requests
//   WRITEDATA          write data
//   BURSTCOUNT         beats in burst, sampled on the first beat
//   BEGINBURSTTRANSFER first-beat marker (informational)
//   READDATA           read data, zero when READDATAVALID is low
//   READDATAVALID      one beat of read data valid
//   WAITREQUEST        slave stall
interface avalon_regfile_slave_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 3
);
  logic [ADDR_W-1:0]   ADDRESS;
  logic [DATA_W/8-1:0] BYTEENABLE;
  logic                READ;
  logic                WRITE;
  logic [DATA_W-1:0]   WRITEDATA;
  logic [BURST_W-1:0]  BURSTCOUNT;
  logic                BEGINBURSTTRANSFER;
  logic [DATA_W-1:0]   READDATA;
  logic                READDATAVALID;
  logic                WAITREQUEST;

  modport master (
    output ADDRESS, BYTEENABLE, READ, WRITE, WRITEDATA, BURSTCOUNT, BEGINBURSTTRANSFER,
    input  READDATA, READDATAVALID, WAITREQUEST
  );

  modport slave (
    input  ADDRESS, BYTEENABLE, READ, WRITE, WRITEDATA, BURSTCOUNT, BEGINBURSTTRANSFER,
    output READDATA, READDATAVALID, WAITREQUEST
  );
endinterface

// File: rtl/avalon_regfile_slave.sv
// Avalon-MM slave register file.
// NUM_REGS word registers with arbitrary byte-enable writes and pipelined
// reads of fixed READ_LATENCY. Out-of-range accesses (index beyond NUM_REGS
// or any address bit above the index field set) drop writes and read zero.
// READ together with WRITE performs the write only.
//
// Optional feature macro: AVS_BURST_EN
//   defined   - incrementing read/write bursts via an IDLE/RD_BURST/WR_BURST
//               FSM; WAITREQUEST is high while a read burst issues its beats.
//   undefined - every transfer is single-beat, BURSTCOUNT and
//               BEGINBURSTTRANSFER are ignored, WAITREQUEST is tied low.
//
// Ports
//   CLK    in  clock, posedge
//   RESET  in  synchronous active-high reset
//   bus    avalon_regfile_slave_if.slave (command, write data, read response)
module avalon_regfile_slave #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int NUM_REGS     = 8,
  parameter int READ_LATENCY = 1,
  parameter int BURST_W      = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  avalon_regfile_slave_if.slave  bus
);

  localparam int BE_W     = DATA_W / 8;
  localparam int WORD_LSB = $clog2(BE_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int HI_SHIFT = WORD_LSB + IDX_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [IDX_W-1:0] addr_idx;
  logic             addr_ok;
  logic             waitreq;
  logic             acc_wr;
  logic             acc_rd;

  // Per-cycle operation selected by the control logic
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_ok;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ok;

  assign addr_idx = bus.ADDRESS[WORD_LSB +: IDX_W];
  assign addr_ok  = ((bus.ADDRESS >> HI_SHIFT) == '0);

  assign acc_wr = bus.WRITE && !waitreq;
  // A read presented together with a write is dropped
  assign acc_rd = bus.READ && !bus.WRITE && !waitreq;

`ifdef AVS_BURST_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ok_q, ok_d;
  logic               multi;
  logic               unused_sink;

  assign multi       = (bus.BURSTCOUNT > BURST_W'(1));
  assign waitreq     = (state_q == RD_BURST);
  assign unused_sink = bus.BEGINBURSTTRANSFER;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
    end
  end
`else
  logic unused_sink;

  assign waitreq     = 1'b0;
  assign unused_sink = ^{bus.BURSTCOUNT, bus.BEGINBURSTTRANSFER};
`endif

  always_comb begin
    wr_en  = acc_wr;
    wr_idx = addr_idx;
    wr_ok  = addr_ok;
    rd_en  = acc_rd;
    rd_idx = addr_idx;
    rd_ok  = addr_ok;
`ifdef AVS_BURST_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    unique case (state_q)
      IDLE: begin
        // First beat is served from ADDRESS; the FSM carries the rest
        if (acc_wr) begin
          if (multi) begin
            state_d = WR_BURST;
            cnt_d   = bus.BURSTCOUNT - BURST_W'(1);
            idx_d   = addr_idx + IDX_W'(1);
            ok_d    = addr_ok;
          end
        end else if (acc_rd && multi) begin
          state_d = RD_BURST;
          cnt_d   = bus.BURSTCOUNT - BURST_W'(1);
          idx_d   = addr_idx + IDX_W'(1);
          ok_d    = addr_ok;
        end
      end
      RD_BURST: begin
        // One self-issued beat per cycle; the bus is stalled meanwhile
        wr_en  = 1'b0;
        rd_en  = 1'b1;
        rd_idx = idx_q;
        rd_ok  = ok_q;
        idx_d  = idx_q + IDX_W'(1);
        cnt_d  = cnt_q - BURST_W'(1);
        if (cnt_q == BURST_W'(1)) begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        // ADDRESS and BURSTCOUNT are ignored; reads are ignored
        rd_en  = 1'b0;
        wr_idx = idx_q;
        wr_ok  = ok_q;
        if (acc_wr) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`endif
  end

  // Register array: byte-lane writes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.BYTEENABLE[b]) begin
          regs_q[wr_idx][8*b +: 8] <= bus.WRITEDATA[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: stage 0 samples the register on acceptance
  logic [READ_LATENCY-1:0] rd_vld_q;
  logic [DATA_W-1:0]       rd_data_q [READ_LATENCY];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q[0] <= rd_en;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    rd_data_q[0] <= rd_ok ? regs_q[rd_idx] : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_data_q[i] <= rd_data_q[i-1];
    end
  end

  assign bus.READDATAVALID = rd_vld_q[READ_LATENCY-1];
  assign bus.READDATA      = rd_vld_q[READ_LATENCY-1] ? rd_data_q[READ_LATENCY-1] : '0;
  assign bus.WAITREQUEST   = waitreq;

endmodule

// File: tb/tb_avalon_regfile_slave.sv
// Bench for avalon_regfile_slave: two instances (READ_LATENCY 1 and 3) share
// one stimulus stream; a reference register array plus per-cycle expected
// read-response and stall tables are compared against both every cycle.
module tb_avalon_regfile_slave;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NR   = 8;
  localparam int BW   = 3;
  localparam int MAXC = 8192;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic [AW-1:0] t_addr;
  logic [3:0]    t_be;
  logic          t_rd, t_wr, t_bbt;
  logic [DW-1:0] t_wdata;
  logic [BW-1:0] t_bc;

  avalon_regfile_slave_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus1 ();
  avalon_regfile_slave_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus3 ();

  assign bus1.ADDRESS = t_addr;      assign bus3.ADDRESS = t_addr;
  assign bus1.BYTEENABLE = t_be;     assign bus3.BYTEENABLE = t_be;
  assign bus1.READ = t_rd;           assign bus3.READ = t_rd;
  assign bus1.WRITE = t_wr;          assign bus3.WRITE = t_wr;
  assign bus1.WRITEDATA = t_wdata;   assign bus3.WRITEDATA = t_wdata;
  assign bus1.BURSTCOUNT = t_bc;     assign bus3.BURSTCOUNT = t_bc;
  assign bus1.BEGINBURSTTRANSFER = t_bbt;
  assign bus3.BEGINBURSTTRANSFER = t_bbt;

  avalon_regfile_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .READ_LATENCY(1), .BURST_W(BW))
    dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1));
  avalon_regfile_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .READ_LATENCY(3), .BURST_W(BW))
    dut3 (.CLK(CLK), .RESET(RESET), .bus(bus3));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] mdl [NR];
  logic          exp_v1 [MAXC];
  logic          exp_v3 [MAXC];
  logic          exp_w  [MAXC];
  logic [DW-1:0] exp_d1 [MAXC];
  logic [DW-1:0] exp_d3 [MAXC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Outputs sampled on the falling edge, away from the active edge
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (mon_en && cyc < MAXC) begin
      chk("rdvalid_l1", bus1.READDATAVALID, exp_v1[cyc]);
      chk("rdata_l1",   bus1.READDATA,      exp_d1[cyc]);
      chk("rdvalid_l3", bus3.READDATAVALID, exp_v3[cyc]);
      chk("rdata_l3",   bus3.READDATA,      exp_d3[cyc]);
      chk("waitreq_l1", bus1.WAITREQUEST,   exp_w[cyc]);
      chk("waitreq_l3", bus3.WAITREQUEST,   exp_w[cyc]);
    end
  end

  // A beat accepted on the edge after falling edge t is seen at t+latency
  task automatic sched(input int t, input logic [DW-1:0] v);
    exp_v1[t+1] = 1'b1; exp_d1[t+1] = v;
    exp_v3[t+3] = 1'b1; exp_d3[t+3] = v;
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a / 4) % NR);
  endfunction

  function automatic bit ok_of(input logic [AW-1:0] a);
    return a < NR * 4;
  endfunction

  task automatic idle();
    @(negedge CLK); #1;
    t_rd = 0; t_wr = 0; t_bbt = 0; t_addr = '0; t_wdata = '0; t_be = '0; t_bc = '0;
  endtask

  task automatic op(input bit rd, input bit wr, input logic [AW-1:0] addr,
                    input logic [DW-1:0] wd, input logic [3:0] be, input logic [BW-1:0] bc);
    int idx;
    bit ok;
    @(negedge CLK); #1;
    t_rd = rd; t_wr = wr; t_addr = addr; t_wdata = wd; t_be = be; t_bc = bc; t_bbt = rd | wr;
    idx = idx_of(addr);
    ok  = ok_of(addr);
    if (rd && !wr) sched(cyc, ok ? mdl[idx] : '0);
    if (wr && ok) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic readall();
    for (int i = 0; i < NR; i++) op(1, 0, AW'(i * 4), '0, '0, BW'(1));
    idle();
  endtask

  task automatic model_reset();
    for (int k = cyc + 1; k < MAXC; k++) begin
      exp_v1[k] = 0; exp_v3[k] = 0; exp_w[k] = 0; exp_d1[k] = '0; exp_d3[k] = '0;
    end
    for (int i = 0; i < NR; i++) mdl[i] = '0;
  endtask

`ifdef AVS_BURST_EN
  task automatic wr_burst(input logic [AW-1:0] addr, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    logic [DW-1:0] d [4];
    int i0;
    bit k0;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    i0 = idx_of(addr);
    k0 = ok_of(addr);
    op(0, 1, addr, d[0], 4'hF, BW'(4));
    for (int k = 1; k < 4; k++) begin
      if (k == 2) idle();
      @(negedge CLK); #1;
      t_wr = 1; t_rd = 1'($urandom % 2); t_addr = $urandom; t_bc = BW'($urandom);
      t_wdata = d[k]; t_be = 4'hF; t_bbt = 0;
      if (k0) mdl[(i0 + k) % NR] = d[k];
    end
    idle();
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input bit do_reset);
    int t0, i0;
    bit k0;
    @(negedge CLK); #1;
    t_rd = 1; t_wr = 0; t_addr = addr; t_bc = BW'(4); t_bbt = 1; t_be = '0;
    t0 = cyc;
    i0 = idx_of(addr);
    k0 = ok_of(addr);
    for (int k = 0; k < 4; k++) begin
      exp_v1[t0+k+1] = 1; exp_d1[t0+k+1] = k0 ? mdl[(i0 + k) % NR] : '0;
      exp_v3[t0+k+3] = 1; exp_d3[t0+k+3] = k0 ? mdl[(i0 + k) % NR] : '0;
    end
    for (int k = 1; k < 4; k++) exp_w[t0+k] = 1;
    if (do_reset) begin
      idle();
      @(negedge CLK); #1;
      RESET = 1;
      model_reset();
      @(negedge CLK); #1;
      RESET = 0;
    end else begin
      // A write offered while stalled must not be taken
      @(negedge CLK); #1;
      t_rd = 0; t_wr = 1; t_addr = addr; t_wdata = $urandom; t_be = 4'hF; t_bc = BW'(1);
      idle();
    end
    repeat (5) idle();
  endtask
`endif

  initial begin
    logic [AW-1:0] ra;
    logic [BW-1:0] rbc;
    for (int k = 0; k < MAXC; k++) begin
      exp_v1[k] = 0; exp_v3[k] = 0; exp_w[k] = 0; exp_d1[k] = '0; exp_d3[k] = '0;
    end
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    t_rd = 0; t_wr = 0; t_bbt = 0; t_addr = '0; t_wdata = '0; t_be = '0; t_bc = '0;

    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    RESET = 0;
    mon_en = 1;
    chk("reset_waitreq", bus1.WAITREQUEST, 1'b0);
    chk("reset_rdvalid", bus1.READDATAVALID, 1'b0);
    chk("reset_rdata", bus3.READDATA, '0);

    // Registers read back zero after reset
    readall();

    // Byte-lane merge
    op(0, 1, 32'h04, 32'hDEADBEEF, 4'b1111, BW'(1));
    op(0, 1, 32'h04, 32'h000000AA, 4'b0001, BW'(1));
    op(0, 1, 32'h04, 32'h55000000, 4'b1000, BW'(1));
    op(1, 0, 32'h04, '0, '0, BW'(1));
    idle();
    chk("merge_rd", bus1.READDATA, 32'h55ADBEAA);

    // Back-to-back reads and the byte-enable-zero no-op
    op(0, 1, 32'h08, 32'h11112222, 4'hF, BW'(1));
    op(0, 1, 32'h0C, 32'h33334444, 4'hF, BW'(1));
    op(0, 1, 32'h0C, 32'hFFFFFFFF, 4'h0, BW'(1));
    op(1, 0, 32'h04, '0, '0, BW'(1));
    op(1, 0, 32'h08, '0, '0, BW'(1));
    op(1, 0, 32'h0C, '0, '0, BW'(1));
    idle();
    repeat (4) idle();

    // Out-of-range and READ+WRITE collisions
    op(1, 0, 32'h40, '0, '0, BW'(1));
    op(0, 1, 32'h40, 32'hCAFEF00D, 4'hF, BW'(1));
    op(0, 1, 32'h8000_0004, 32'hCAFEF00D, 4'hF, BW'(1));
    op(1, 1, 32'h08, 32'h00000012, 4'hF, BW'(1));
    idle();
    readall();

`ifdef AVS_BURST_EN
    wr_burst(32'h18, 32'd1, 32'd2, 32'd3, 32'd4);
    readall();
    rd_burst(32'h18, 1'b0);
    readall();
`endif

    // Randomized single-beat traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom % 8 == 0) ra = $urandom;
      else if ($urandom % 8 == 0) ra = AW'($urandom % 256);
      else ra = AW'(($urandom % NR) * 4);
`ifdef AVS_BURST_EN
      rbc = BW'($urandom % 2);
`else
      rbc = BW'($urandom);
`endif
      if ($urandom % 6 == 0) idle();
      else op(1'($urandom % 2), 1'($urandom % 2), ra, $urandom, 4'($urandom), rbc);
    end
    idle();
    readall();

`ifdef AVS_BURST_EN
    rd_burst(32'h18, 1'b1);
    readall();
    op(0, 1, 32'h00, 32'h0BADF00D, 4'hF, BW'(1));
    idle();
`endif

    // Reset while reads are still in the pipeline
    op(0, 1, 32'h10, 32'h5A5A5A5A, 4'hF, BW'(1));
    op(1, 0, 32'h10, '0, '0, BW'(1));
    op(1, 0, 32'h00, '0, '0, BW'(1));
    @(negedge CLK); #1;
    t_rd = 0; t_wr = 0; RESET = 1;
    model_reset();
    @(negedge CLK); #1;
    RESET = 0;
    chk("midreset_waitreq", bus1.WAITREQUEST, 1'b0);
    readall();
    repeat (6) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
